// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM round-robin arbiter.
// Optional statistics counters in the top are enabled by SRAM_ARB_STATS_EN.
package sram_arb_pkg;

  localparam int ARB_DW = 32;
  localparam int ARB_AW = 11;

  localparam logic P0 = 1'b0;
  localparam logic P1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_rr_pick.sv
// Combinational 2-way picker: a locked owner keeps priority while it requests,
// otherwise contention is resolved by the round-robin pointer.
module sram_rr_pick
  import sram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       rr_ptr,
  input  owner_e     owner,
  output logic [1:0] gnt
);

  // Owner first, then round-robin on contention, else the lone requester.
  always_comb begin
    gnt = 2'b00;
    if ((owner == OWN0) && req[P0]) begin
      gnt = 2'b01;
    end else if ((owner == OWN1) && req[P1]) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      gnt = (rr_ptr == P1) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Shares one single-port SRAM between two valid/ready requesters with bounded lock bursts.
// Define SRAM_ARB_STATS_EN to add saturating grant/conflict counters.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DW        = ARB_DW,
  parameter int AW        = ARB_AW,
  parameter int MAX_BURST = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          req0,
  input  logic          we0,
  input  logic          lock0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic          lock1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          sram_cen,
  output logic          sram_wen,
  output logic [AW-1:0] sram_a,
  output logic [DW-1:0] sram_d,
  input  logic [DW-1:0] sram_q
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [31:0]   stat_gnt0,
  output logic [31:0]   stat_gnt1,
  output logic [31:0]   stat_conflict
`endif
);

  localparam logic [8:0] MAX_B9 = 9'(MAX_BURST);

  owner_e        owner_r, owner_s;
  logic          rr_ptr_r, rr_ptr_s;
  logic [7:0]    burst_cnt_r, burst_cnt_s;
  logic [8:0]    base_s, next_cnt_s;
  logic [1:0]    pick_s, gnt_s;
  logic          any_gnt_s, gnt_port_s;
  logic          sel_we_s, sel_lock_s;
  logic [AW-1:0] sel_addr_s, a_hold_r;
  logic [DW-1:0] sel_wdata_s, d_hold_r, rdata_r;
  logic          rvalid0_r, rvalid1_r;

  sram_rr_pick u_pick (
    .req    ({req1, req0}),
    .rr_ptr (rr_ptr_r),
    .owner  (owner_r),
    .gnt    (pick_s)
  );

  // Reset suppresses grants for the whole reset cycle, not just from the next edge.
  assign gnt_s      = RESET_N ? pick_s : 2'b00;
  assign any_gnt_s  = |gnt_s;
  assign gnt_port_s = gnt_s[1];

  // Granted-port mux plus ownership / burst / round-robin next state.
  always_comb begin
    sel_we_s    = gnt_port_s ? we1    : we0;
    sel_lock_s  = gnt_port_s ? lock1  : lock0;
    sel_addr_s  = gnt_port_s ? addr1  : addr0;
    sel_wdata_s = gnt_port_s ? wdata1 : wdata0;
    base_s      = 9'd0;
    next_cnt_s  = 9'd1;
    owner_s     = IDLE;
    burst_cnt_s = 8'd0;
    rr_ptr_s    = rr_ptr_r;
    if (any_gnt_s) begin
      rr_ptr_s = ~gnt_port_s;
      if (((owner_r == OWN0) && (gnt_port_s == P0)) || ((owner_r == OWN1) && (gnt_port_s == P1))) begin
        base_s = {1'b0, burst_cnt_r};
      end else begin
        base_s = 9'd0;
      end
      next_cnt_s = base_s + 9'd1;
      if (sel_lock_s && (next_cnt_s < MAX_B9)) begin
        owner_s     = gnt_port_s ? OWN1 : OWN0;
        burst_cnt_s = next_cnt_s[7:0];
      end else begin
        owner_s     = IDLE;
        burst_cnt_s = 8'd0;
      end
    end else begin
      owner_s     = IDLE;
      burst_cnt_s = 8'd0;
    end
  end

  // Arbiter state, read-return pipeline and held SRAM pin values.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      owner_r     <= IDLE;
      rr_ptr_r    <= P0;
      burst_cnt_r <= 8'd0;
      rvalid0_r   <= 1'b0;
      rvalid1_r   <= 1'b0;
      a_hold_r    <= {AW{1'b0}};
      d_hold_r    <= {DW{1'b0}};
      rdata_r     <= {DW{1'b0}};
    end else begin
      owner_r     <= owner_s;
      rr_ptr_r    <= rr_ptr_s;
      burst_cnt_r <= burst_cnt_s;
      rvalid0_r   <= gnt_s[0] & ~we0;
      rvalid1_r   <= gnt_s[1] & ~we1;
      if (any_gnt_s) begin
        a_hold_r <= sel_addr_s;
        d_hold_r <= sel_wdata_s;
      end
      if (rvalid0_r | rvalid1_r) begin
        rdata_r <= sram_q;
      end
    end
  end

  // Pending returns are discarded as soon as reset is seen.
  assign gnt0     = gnt_s[0];
  assign gnt1     = gnt_s[1];
  assign rvalid0  = rvalid0_r & RESET_N;
  assign rvalid1  = rvalid1_r & RESET_N;
  assign sram_cen = ~any_gnt_s;
  assign sram_wen = any_gnt_s ? ~sel_we_s : 1'b1;
  assign sram_a   = !RESET_N ? {AW{1'b0}} : (any_gnt_s ? sel_addr_s  : a_hold_r);
  assign sram_d   = !RESET_N ? {DW{1'b0}} : (any_gnt_s ? sel_wdata_s : d_hold_r);
  assign rdata    = !RESET_N ? {DW{1'b0}} : ((rvalid0_r | rvalid1_r) ? sram_q : rdata_r);

`ifdef SRAM_ARB_STATS_EN
  logic [31:0] stat_gnt0_r, stat_gnt1_r, stat_conflict_r;

  // Saturating grant and contention counters.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      stat_gnt0_r     <= 32'd0;
      stat_gnt1_r     <= 32'd0;
      stat_conflict_r <= 32'd0;
    end else begin
      if (gnt_s[0] && (stat_gnt0_r != 32'hFFFF_FFFF)) begin
        stat_gnt0_r <= stat_gnt0_r + 32'd1;
      end
      if (gnt_s[1] && (stat_gnt1_r != 32'hFFFF_FFFF)) begin
        stat_gnt1_r <= stat_gnt1_r + 32'd1;
      end
      if (req0 && req1 && (stat_conflict_r != 32'hFFFF_FFFF)) begin
        stat_conflict_r <= stat_conflict_r + 32'd1;
      end
    end
  end

  assign stat_gnt0     = stat_gnt0_r;
  assign stat_gnt1     = stat_gnt1_r;
  assign stat_conflict = stat_conflict_r;
`endif

endmodule
